// File: rtl/rca_bist_ctrl.sv
// Exhaustive self-test sequencer for an N-bit ripple-carry adder; each vector takes SETTLE+2 cycles.
// No backpressure: start is ignored while busy, abort drops back to idle keeping results for debug.
module rca_bist_ctrl #(
    parameter int N      = 4,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [N-1:0]       a_out,
    output logic [N-1:0]       b_out,
    output logic               cin_out,
    input  logic [N-1:0]       sum_in,
    input  logic               cout_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic               first_err_valid,
    output logic [2*N:0]       first_err_vec
);
    localparam int VW = 2*N+1;
    localparam logic [3:0] SETTLE_V = 4'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [VW-1:0]    idx;
    logic [VW-1:0]    idx_inc;
    logic [3:0]       settle_cnt;
    logic [N:0]       expected;
    logic             mismatch;
    logic             last;
    logic [ERR_W-1:0] err_nxt;

    always_comb begin
        expected = {1'b0, a_out} + {1'b0, b_out} + {{N{1'b0}}, cin_out};
        mismatch = ({cout_in, sum_in} != expected);
        last     = (idx == {VW{1'b1}});
        idx_inc  = idx + 1'b1;
        // pass must see the last vector's result, so it is judged on the post-update count
        err_nxt  = (mismatch && err_count != {ERR_W{1'b1}}) ? err_count + 1'b1 : err_count;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (abort)                state_nxt = S_IDLE;
                else if (settle_cnt == 0) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (abort)     state_nxt = S_IDLE;
                else if (last) state_nxt = S_DONE;
                else           state_nxt = S_SETTLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx             <= '0;
            settle_cnt      <= '0;
            a_out           <= '0;
            b_out           <= '0;
            cin_out         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx                      <= '0;
                        {a_out, b_out, cin_out}  <= '0;
                        settle_cnt               <= SETTLE_V;
                        err_count                <= '0;
                        first_err_valid          <= 1'b0;
                        first_err_vec            <= '0;
                        done                     <= 1'b0;
                        pass                     <= 1'b0;
                        busy                     <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (abort)                 busy       <= 1'b0;
                    else if (settle_cnt != 0)  settle_cnt <= settle_cnt - 1'b1;
                end
                S_CHECK: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else begin
                        err_count <= err_nxt;
                        if (mismatch && !first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= idx;
                        end
                        if (last) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (err_nxt == '0);
                        end else begin
                            idx                     <= idx_inc;
                            {a_out, b_out, cin_out} <= idx_inc;
                            settle_cnt              <= SETTLE_V;
                        end
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_rca_bist_ctrl.sv
// Bench for rca_bist_ctrl: default instance with switchable sum[0] stuck-at-0 fault,
// plus a saturating (ERR_W=4, always faulty) and a SETTLE=0 instance.
module tb_rca_bist_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cyc = 0;

    typedef struct {
        int cycles;
        int err;
        int pass;
        int fv;
        int fev;
    } exp_t;
    exp_t exp_q[$];

    // instance 0: default parameters
    logic       start0 = 1'b0, abort0 = 1'b0, fault0 = 1'b0;
    logic [3:0] a0, b0, sum0;
    logic       cin0, cout0, busy0, done0, pass0, fv0;
    logic [15:0] err0;
    logic [8:0] fev0;
    logic [4:0] r0;
    assign r0    = {1'b0, a0} + {1'b0, b0} + {4'b0, cin0};
    assign sum0  = fault0 ? {r0[3:1], 1'b0} : r0[3:0];
    assign cout0 = r0[4];

    rca_bist_ctrl u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .a_out(a0), .b_out(b0), .cin_out(cin0), .sum_in(sum0), .cout_in(cout0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_valid(fv0), .first_err_vec(fev0)
    );

    // instance 1: 4-bit error counter, adder always faulty
    logic       start1 = 1'b0;
    logic [3:0] a1, b1, sum1;
    logic       cin1, cout1, busy1, done1, pass1, fv1;
    logic [3:0] err1;
    logic [8:0] fev1;
    logic [4:0] r1;
    assign r1    = {1'b0, a1} + {1'b0, b1} + {4'b0, cin1};
    assign sum1  = {r1[3:1], 1'b0};
    assign cout1 = r1[4];

    rca_bist_ctrl #(.N(4), .SETTLE(1), .ERR_W(4)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
        .a_out(a1), .b_out(b1), .cin_out(cin1), .sum_in(sum1), .cout_in(cout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_valid(fv1), .first_err_vec(fev1)
    );

    // instance 2: no settle cycles, correct adder
    logic       start2 = 1'b0;
    logic [3:0] a2, b2, sum2;
    logic       cin2, cout2, busy2, done2, pass2, fv2;
    logic [15:0] err2;
    logic [8:0] fev2;
    assign {cout2, sum2} = {1'b0, a2} + {1'b0, b2} + {4'b0, cin2};

    rca_bist_ctrl #(.N(4), .SETTLE(0), .ERR_W(16)) u2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .a_out(a2), .b_out(b2), .cin_out(cin2), .sum_in(sum2), .cout_in(cout2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_valid(fv2), .first_err_vec(fev2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: every rising edge of done on instance 0 is scored against the queue
    logic done0_d = 1'b0;
    always @(negedge clk) begin
        if (done0 && !done0_d) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_done: got done with empty queue, expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("run_cycles", cyc - start_cyc, e.cycles);
                chk("run_err_count", int'(err0), e.err);
                chk("run_pass", int'(pass0), e.pass);
                chk("run_first_err_valid", int'(fv0), e.fv);
                chk("run_first_err_vec", int'(fev0), e.fev);
                chk("run_busy_low", int'(busy0), 0);
            end
        end
        done0_d = done0;
    end

    task automatic go0();
        start0 = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done0();
        int n = 0;
        while (!done0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done0) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic chk_vec(input string name, input int v);
        chk({name, "_a"}, int'(a0), (v >> 5) & 15);
        chk({name, "_b"}, int'(b0), (v >> 1) & 15);
        chk({name, "_cin"}, int'(cin0), v & 1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ops"}, int'({a0, b0, cin0}), 0);
        chk({name, "_busy"}, int'(busy0), 0);
        chk({name, "_done"}, int'(done0), 0);
        chk({name, "_pass"}, int'(pass0), 0);
        chk({name, "_err"}, int'(err0), 0);
        chk({name, "_fv"}, int'(fv0), 0);
        chk({name, "_fev"}, int'(fev0), 0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk_zero("reset");
        chk("reset_u1_err", int'(err1), 0);
        chk("reset_u2_done", int'(done2), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy0), 0);

        // golden run on u0, saturating run on u1, SETTLE=0 run on u2
        exp_q.push_back('{1536, 0, 1, 0, 0});
        start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        for (int t = 0; t <= 1540; t++) begin
            start2 = (t == 500);
            if (t == 0)    chk("golden_busy", int'(busy0), 1);
            if (t == 1)    chk_vec("vec0", 0);
            if (t == 4)    chk_vec("vec1", 1);
            if (t == 7)    chk_vec("vec2", 2);
            if (t == 1534) chk_vec("vec511", 511);
            if (t == 1023) chk("s0_done_early", int'(done2), 0);
            if (t == 1024) begin
                chk("s0_done", int'(done2), 1);
                chk("s0_pass", int'(pass2), 1);
                chk("s0_err", int'(err2), 0);
            end
            if (t == 1535) chk("sat_done_early", int'(done1), 0);
            if (t == 1536) begin
                chk("sat_done", int'(done1), 1);
                chk("sat_err", int'(err1), 15);
                chk("sat_pass", int'(pass1), 0);
                chk("sat_fev", int'(fev1), 1);
            end
            @(negedge clk);
        end
        start2 = 1'b0;
        chk("golden_scored", exp_q.size(), 0);
        chk("done_hold_vec_a", int'(a0), 15);

        // stuck-at fault run, with a start pulse mid-run that must be ignored
        fault0 = 1'b1;
        exp_q.push_back('{1536, 256, 0, 1, 1});
        go0();
        repeat (700) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("ignored_start_busy", int'(busy0), 1);
        wait_done0();

        // start from DONE: done drops and vector 0 is reapplied
        go0();
        chk("restart_done_low", int'(done0), 0);
        chk("restart_busy", int'(busy0), 1);
        chk("restart_ops", int'({a0, b0, cin0}), 0);
        chk("restart_err_clr", int'(err0), 0);

        // abort during CHECK of vector 100 (3+2+0: a mismatching vector under the fault)
        while (cyc - start_cyc < 302) @(negedge clk);
        chk_vec("vec100", 100);
        chk("pre_abort_err", int'(err0), 50);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("abort_busy", int'(busy0), 0);
        chk("abort_done", int'(done0), 0);
        chk("abort_err_held", int'(err0), 50);
        chk("abort_fv", int'(fv0), 1);
        chk("abort_fev", int'(fev0), 1);
        chk_vec("abort_ops_held", 100);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", int'(busy0), 0);

        // clean run after abort
        fault0 = 1'b0;
        exp_q.push_back('{1536, 0, 1, 0, 0});
        go0();
        wait_done0();

        // asynchronous reset mid-run at vector 37
        go0();
        while (cyc - start_cyc < 112) @(negedge clk);
        chk_vec("vec37", 37);
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", int'(busy0), 0);
        exp_q.push_back('{1536, 0, 1, 0, 0});
        go0();
        wait_done0();

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rca_bist_ctrl.md
Name: rca_bist_ctrl

Overview:
Self-test sequencer that sits around an N-bit ripple-carry adder (RCA_4 class). It drives the adder's a/b/cin inputs and consumes its sum/cout outputs. It walks all 2^(2N+1) operand combinations, compares each result against a golden N+1-bit sum, counts mismatches and records the first failing vector. It is used as the on-chip replacement for the exhaustive simulation loop, and as a post-synthesis sign-off block for every adder variant.

Parameters:
N, 4, adder operand width.
SETTLE, 1, extra cycles (0..15) the adder output is allowed to settle before sampling.
ERR_W, 16, width of the mismatch counter.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; begins a run from IDLE or DONE.
abort  in  1  synchronous; terminates a run in progress.
a_out  out  N  operand A to the adder (registered).
b_out  out  N  operand B to the adder (registered).
cin_out  out  1  carry-in to the adder (registered).
sum_in  in  N  adder sum.
cout_in  in  1  adder carry-out.
busy  out  1  run in progress (SETTLE or CHECK).
done  out  1  run completed; held until the next start or reset.
pass  out  1  valid with done: 1 if err_count==0.
err_count  out  ERR_W  saturating mismatch count.
first_err_valid  out  1  at least one mismatch seen this run.
first_err_vec  out  2N+1  index of the first mismatching vector.

Behaviour:
- Vector index v (2N+1 bits): a=v[2N:N+1], b=v[N:1], cin=v[0]. Order: a outermost, cin innermost. v runs 0..2^(2N+1)-1 (511 for N=4).
- Reset (async, immediate): state=IDLE; a_out, b_out, cin_out, busy, done, pass, err_count, first_err_valid, first_err_vec, index and settle counter all 0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1:
  - index<=0; operands<=vector 0; settle_cnt<=SETTLE.
  - err_count, first_err_valid, first_err_vec, done, pass<=0.
  - Next state SETTLE.
- SETTLE: if settle_cnt==0, go to CHECK; otherwise decrement. Occupies SETTLE+1 cycles. Operands are held.
- CHECK: expected = a_out + b_out + cin_out, computed at N+1 bits.
  - Mismatch: {cout_in,sum_in} != expected.
  - On mismatch: err_count increments, saturating at 2^ERR_W-1. If first_err_valid=0, first_err_vec<=index and first_err_valid<=1.
  - If index==last: next state DONE. Otherwise index+1, operands updated, settle_cnt<=SETTLE, next state SETTLE.
- Timing:
  - Each vector takes SETTLE+2 cycles.
  - done rises at the clock edge 2^(2N+1)*(SETTLE+2) cycles after the start edge. For defaults that is 1536.
  - pass=(err_count==0) is registered on the same edge.
- DONE:
  - done=1 and busy=0.
  - Results and operands hold the last vector until start.
- busy=1 exactly in SETTLE and CHECK.
- start while busy is ignored.
- abort=1 in SETTLE or CHECK:
  - Next state IDLE; busy<=0; done stays 0.
  - err_count and first_err are held for debug.
  - Operands are held.
  - Any mismatch in that same CHECK cycle is not counted.
- abort has priority over start. abort in IDLE or DONE has no effect.
- Simultaneous start and rst: reset wins.

Test Plan:
- Reset: assert rst mid-run at vector 37 -> all outputs 0 immediately, state IDLE; after release, start gives a full clean run.
- Golden run (N=4, SETTLE=1, correct RCA_4 attached):
  - Start pulse -> operand sequence (0,0,0), (0,0,1), (0,1,0) … (15,15,1).
  - done at cycle 1536; pass=1; err_count=0; first_err_valid=0.
- Stuck fault (sum_in[0] forced 0):
  - err_count=256 at done; pass=0.
  - first_err_valid=1; first_err_vec=1 (a=0, b=0, cin=1).
- Saturation (ERR_W=4, same fault) -> err_count=15 at done, pass=0.
- Abort and restart:
  - abort during CHECK of vector 100 -> next cycle busy=0, done=0, err_count unchanged.
  - New start -> full run, done at 1536 cycles, pass=1.
- SETTLE=0 and start handling:
  - SETTLE=0 -> done at cycle 1024.
  - start pulsed while busy -> ignored, run not restarted.
  - start in DONE -> done drops next edge and vector 0 is reapplied.
